line_raster_gen: RTL and testbench

Parametrised, handshaked successor to the single-step point generator. It accepts one line segment (x0,y0)->(x1,y1) and streams every Bresenham pixel of that segment, both endpoints included, one point per accepted handshake. Unlike the single-step generator it handles all eight octants: steep lines, negative dx and negative dy. It also handles output backpressure and signals completion. It sits between triangle/edge setup and the fragment/framebuffer writer in the rasterizer.

---
 rtl/raster_pkg.sv | 22 ++
 rtl/line_setup.sv | 50 +++++
 rtl/line_raster_gen.sv | 172 +++++++++++++++++
 tb/tb_line_raster_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared rasterizer types: coordinate/delta widths, line FSM states and a point record
// used by the edge walker and the fragment writer.
package raster_pkg;

  localparam int COORD_W_DEFAULT = 10;

  typedef logic signed [COORD_W_DEFAULT-1:0] coord_t;
  typedef logic [COORD_W_DEFAULT:0]          delta_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: |dx|, -|dy|, step directions and initial error
// for one segment, widened so the extreme coordinates cannot overflow.
module line_setup
  import raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int DELTA_W = COORD_W + 1,
  parameter int ERR_W   = DELTA_W + 2
) (
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic signed [ERR_W-1:0]   dx,
  output logic signed [ERR_W-1:0]   dy,
  output logic signed [ERR_W-1:0]   err,
  output logic                      sx_neg,
  output logic                      sy_neg
);

  localparam int EXT_W = DELTA_W + 1 - COORD_W;
  localparam int PAD_W = ERR_W - DELTA_W - 1;

  logic signed [DELTA_W:0] ddx_s;
  logic signed [DELTA_W:0] ddy_s;
  logic signed [DELTA_W:0] adx_s;
  logic signed [DELTA_W:0] ady_s;

  // Signed differences, their magnitudes and the derived setup values.
  always_comb begin
    ddx_s = $signed({{EXT_W{x1[COORD_W-1]}}, x1}) - $signed({{EXT_W{x0[COORD_W-1]}}, x0});
    ddy_s = $signed({{EXT_W{y1[COORD_W-1]}}, y1}) - $signed({{EXT_W{y0[COORD_W-1]}}, y0});
    if (ddx_s[DELTA_W]) begin
      adx_s = -ddx_s;
    end else begin
      adx_s = ddx_s;
    end
    if (ddy_s[DELTA_W]) begin
      ady_s = -ddy_s;
    end else begin
      ady_s = ddy_s;
    end
    dx     = $signed({{PAD_W{1'b0}}, adx_s});
    dy     = -$signed({{PAD_W{1'b0}}, ady_s});
    err    = dx + dy;
    sx_neg = ddx_s[DELTA_W];
    sy_neg = ddy_s[DELTA_W];
  end

endmodule

// File: rtl/line_raster_gen.sv
// Handshaked all-octant Bresenham line generator: latches a segment, then streams
// every pixel (endpoints included) under pt_valid/pt_ready and pulses done at the end.
module line_raster_gen
  import raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int DELTA_W = COORD_W + 1,
  parameter int ERR_W   = DELTA_W + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic                      busy,
  output logic                      pt_valid,
  input  logic                      pt_ready,
  output logic signed [COORD_W-1:0] pt_x,
  output logic signed [COORD_W-1:0] pt_y,
  output logic                      pt_last,
  output logic                      done
);

  localparam logic signed [COORD_W-1:0] ONE      = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic signed [ERR_W-1:0]   ERR_ZERO = {ERR_W{1'b0}};

  state_t                    state_r, state_next_s;
  logic signed [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
  logic signed [COORD_W-1:0] cur_x_r, cur_y_r, next_x_s, next_y_s;
  logic signed [ERR_W-1:0]   dx_r, dy_r, err_r, err_next_s;
  logic                      sx_neg_r, sy_neg_r;
  logic                      busy_r, pt_valid_r, pt_last_r, done_r;
  logic signed [ERR_W-1:0]   set_dx_s, set_dy_s, set_err_s;
  logic                      set_sx_neg_s, set_sy_neg_s;
  logic signed [ERR_W:0]     e2_s;
  logic                      step_x_s, step_y_s, hs_s;

  line_setup #(
    .COORD_W(COORD_W),
    .DELTA_W(DELTA_W),
    .ERR_W  (ERR_W)
  ) u_setup (
    .x0    (x0_r),
    .y0    (y0_r),
    .x1    (x1_r),
    .y1    (y1_r),
    .dx    (set_dx_s),
    .dy    (set_dy_s),
    .err   (set_err_s),
    .sx_neg(set_sx_neg_s),
    .sy_neg(set_sy_neg_s)
  );

  // Bresenham step from the current pixel; both axis updates use the pre-step error.
  always_comb begin
    hs_s     = pt_valid_r && pt_ready;
    e2_s     = $signed({err_r, 1'b0});
    step_x_s = (e2_s >= $signed({dy_r[ERR_W-1], dy_r}));
    step_y_s = (e2_s <= $signed({dx_r[ERR_W-1], dx_r}));
    if (step_x_s) begin
      next_x_s = sx_neg_r ? (cur_x_r - ONE) : (cur_x_r + ONE);
    end else begin
      next_x_s = cur_x_r;
    end
    if (step_y_s) begin
      next_y_s = sy_neg_r ? (cur_y_r - ONE) : (cur_y_r + ONE);
    end else begin
      next_y_s = cur_y_r;
    end
    err_next_s = err_r + (step_x_s ? dy_r : ERR_ZERO) + (step_y_s ? dx_r : ERR_ZERO);
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: state_next_s = EMIT;
      EMIT: begin
        if (hs_s && pt_last_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = EMIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Endpoint latch, walker registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r       <= '0;
      y0_r       <= '0;
      x1_r       <= '0;
      y1_r       <= '0;
      cur_x_r    <= '0;
      cur_y_r    <= '0;
      dx_r       <= '0;
      dy_r       <= '0;
      err_r      <= '0;
      sx_neg_r   <= 1'b0;
      sy_neg_r   <= 1'b0;
      pt_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      pt_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x0_r <= x0;
            y0_r <= y0;
            x1_r <= x1;
            y1_r <= y1;
          end
        end
        SETUP: begin
          dx_r      <= set_dx_s;
          dy_r      <= set_dy_s;
          err_r     <= set_err_s;
          sx_neg_r  <= set_sx_neg_s;
          sy_neg_r  <= set_sy_neg_s;
          cur_x_r   <= x0_r;
          cur_y_r   <= y0_r;
          pt_last_r <= (x0_r == x1_r) && (y0_r == y1_r);
        end
        EMIT: begin
          if (hs_s && !pt_last_r) begin
            cur_x_r   <= next_x_s;
            cur_y_r   <= next_y_s;
            err_r     <= err_next_s;
            pt_last_r <= (next_x_s == x1_r) && (next_y_s == y1_r);
          end else if (hs_s) begin
            pt_last_r <= 1'b0;
          end
        end
        DONE: pt_last_r <= 1'b0;
        default: pt_last_r <= 1'b0;
      endcase
      busy_r     <= (state_next_s != IDLE);
      pt_valid_r <= (state_next_s == EMIT);
      done_r     <= (state_next_s == DONE);
    end
  end

  assign busy     = busy_r;
  assign pt_valid = pt_valid_r;
  assign pt_last  = pt_last_r;
  assign done     = done_r;
  assign pt_x     = cur_x_r;
  assign pt_y     = cur_y_r;

endmodule

// File: tb/tb_line_raster_gen.sv
// Directed bench for line_raster_gen: hand-written point lists plus a real-valued
// nearest-pixel reference (ties round toward the endpoint) for the longer lines.
module tb_line_raster_gen;

  localparam int CW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 pt_ready;
  logic signed [CW-1:0] x0, y0, x1, y1;
  logic                 busy, pt_valid, pt_last, done;
  logic signed [CW-1:0] pt_x, pt_y;

  int checks   = 0;
  int failures = 0;
  int obs_x[$];
  int obs_y[$];

  always #5 clk = ~clk;

  line_raster_gen #(.COORD_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .busy    (busy),
    .pt_valid(pt_valid),
    .pt_ready(pt_ready),
    .pt_x    (pt_x),
    .pt_y    (pt_y),
    .pt_last (pt_last),
    .done    (done)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Nearest minor-axis offset for major step k; exact halves round away from the start.
  function automatic int minor_off(input int k, input int amin, input int amaj);
    if (amaj == 0) return 0;
    return int'($floor(real'(k) * real'(amin) / real'(amaj) + 0.5));
  endfunction

  task automatic gold_point(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int k, output int ex, output int ey);
    int adx, ady, sx, sy;
    adx = iabs(ax1 - ax0);
    ady = iabs(ay1 - ay0);
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    if (adx >= ady) begin
      ex = ax0 + sx * k;
      ey = ay0 + sy * minor_off(k, ady, adx);
    end else begin
      ey = ay0 + sy * k;
      ex = ax0 + sx * minor_off(k, adx, ady);
    end
  endtask

  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input bit rnd, input int busy_start_at, input int rst_at);
    int   n, idx, cyc, ex, ey;
    bit   held, rdy;
    logic signed [CW-1:0] hx, hy;
    logic hl;
    n = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
    obs_x.delete();
    obs_y.delete();
    @(negedge clk);
    x0 = ax0[CW-1:0]; y0 = ay0[CW-1:0]; x1 = ax1[CW-1:0]; y1 = ay1[CW-1:0];
    start = 1'b1;
    pt_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("setup_busy", busy, 1);
    check_eq("setup_valid", pt_valid, 0);
    @(negedge clk);
    check_eq("first_valid", pt_valid, 1);
    idx = 0; cyc = 0; held = 1'b0; hx = '0; hy = '0; hl = 1'b0;
    while (idx < n && cyc < 5000) begin
      if (held) begin
        check_eq("hold_valid", pt_valid, 1);
        check_eq("hold_x", pt_x, hx);
        check_eq("hold_y", pt_y, hy);
        check_eq("hold_last", pt_last, hl);
      end
      if (rst_at >= 0 && idx == rst_at) begin
        pt_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", pt_valid, 0);
        check_eq("rst_x", pt_x, 0);
        check_eq("rst_y", pt_y, 0);
        check_eq("rst_last", pt_last, 0);
        check_eq("rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
      if (idx == busy_start_at) begin
        start = 1'b1;
        x0 = 10'sd3; y0 = -10'sd9; x1 = 10'sd40; y1 = 10'sd2;
      end else begin
        start = 1'b0;
      end
      rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      pt_ready = rdy;
      if (pt_valid && rdy) begin
        gold_point(ax0, ay0, ax1, ay1, idx, ex, ey);
        check_eq("pt_x", pt_x, ex);
        check_eq("pt_y", pt_y, ey);
        check_eq("pt_last", pt_last, (idx == n - 1) ? 1 : 0);
        obs_x.push_back(int'(pt_x));
        obs_y.push_back(int'(pt_y));
        idx++;
        held = 1'b0;
      end else begin
        held = pt_valid;
        hx = pt_x; hy = pt_y; hl = pt_last;
      end
      @(negedge clk);
      cyc++;
    end
    pt_ready = 1'b0;
    start = 1'b0;
    check_eq("npoints", idx, n);
    check_eq("done_pulse", done, 1);
    check_eq("done_valid", pt_valid, 0);
    check_eq("done_busy", busy, 1);
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic check_list(input string tag, input int ex[$], input int ey[$]);
    check_eq({tag, "_len"}, obs_x.size(), ex.size());
    for (int i = 0; i < ex.size() && i < obs_x.size(); i++) begin
      check_eq({tag, "_x"}, obs_x[i], ex[i]);
      check_eq({tag, "_y"}, obs_y[i], ey[i]);
    end
  endtask

  initial begin
    int hx[$];
    int hy[$];
    rst_n = 1'b0; start = 1'b0; pt_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", pt_valid, 0);
    check_eq("reset_last", pt_last, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_x", pt_x, 0);
    check_eq("reset_y", pt_y, 0);
    rst_n = 1'b1;

    run_line(0, 0, 4, -2, 1'b0, -1, -1);
    hx = '{0, 1, 2, 3, 4};  hy = '{0, -1, -1, -2, -2};
    check_list("shallow", hx, hy);

    run_line(0, 0, 1, 3, 1'b0, -1, -1);
    hx = '{0, 0, 1, 1};  hy = '{0, 1, 2, 3};
    check_list("steep", hx, hy);

    run_line(0, 0, -1, -3, 1'b0, -1, -1);
    hx = '{0, 0, -1, -1};  hy = '{0, -1, -2, -3};
    check_list("steep_neg", hx, hy);

    run_line(0, 0, 100, -50, 1'b1, -1, -1);
    check_eq("bp_count", obs_x.size(), 101);

    run_line(5, 5, 5, 5, 1'b0, -1, -1);
    hx = '{5};  hy = '{5};
    check_list("degen", hx, hy);

    run_line(-3, 7, 3, 7, 1'b0, -1, -1);
    hx = '{-3, -2, -1, 0, 1, 2, 3};  hy = '{7, 7, 7, 7, 7, 7, 7};
    check_list("horiz", hx, hy);

    run_line(-512, -512, 511, 511, 1'b0, 500, -1);
    check_eq("extreme_count", obs_x.size(), 1024);

    run_line(0, 0, 20, 5, 1'b0, -1, 9);
    check_eq("trunc_count", obs_x.size(), 9);

    run_line(2, -3, -9, 4, 1'b0, -1, -1);
    check_eq("fresh_count", obs_x.size(), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
